// File: rtl/seven_seg_scan.sv
// Latches a packed BCD word and time-multiplexes it onto a common-anode seven-segment display.
// Optional edit-digit blinking is enabled with the SEVEN_SEG_BLINK_EN macro.
module seven_seg_scan #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 100000,
   parameter int BLINK_DIV   = 25000000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [4*NUM_DIGITS-1:0]   digits_in,
   input  logic                      load,
   input  logic [NUM_DIGITS-1:0]     blank_mask,
   input  logic [NUM_DIGITS-1:0]     dp_mask,
`ifdef SEVEN_SEG_BLINK_EN
   input  logic [NUM_DIGITS-1:0]     edit_sel,
`endif
   output logic [6:0]                seg,
   output logic                      dp,
   output logic [NUM_DIGITS-1:0]     an
);

   localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int TICK_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(REFRESH_DIV - 1);

   logic [4*NUM_DIGITS-1:0] shadow_reg;
   logic [TICK_W-1:0]       tick_reg;
   logic [IDX_W-1:0]        digit_reg;
   logic [3:0]              nibble [NUM_DIGITS];
   logic [3:0]              cur_nibble;
   logic                    dark;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_nibble
         assign nibble[gi] = shadow_reg[gi*4 +: 4];
      end
   endgenerate

   assign cur_nibble = nibble[digit_reg];

   function automatic logic [6:0] decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b0111111;
      endcase
      return s;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_reg <= '0;
      end else if (load) begin
         shadow_reg <= digits_in;
      end
   end

   // Each digit stays selected for REFRESH_DIV cycles, including the first after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_reg  <= '0;
         digit_reg <= '0;
      end else if (tick_reg == LAST_TICK) begin
         tick_reg  <= '0;
         digit_reg <= (digit_reg == LAST_IDX) ? '0 : digit_reg + 1'b1;
      end else begin
         tick_reg  <= tick_reg + 1'b1;
      end
   end

`ifdef SEVEN_SEG_BLINK_EN
   localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [BLINK_W-1:0] LAST_BLINK = BLINK_W'(BLINK_DIV - 1);

   logic [BLINK_W-1:0] blink_cnt_reg;
   logic               blink_phase_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         blink_cnt_reg   <= '0;
         blink_phase_reg <= 1'b0;
      end else if (blink_cnt_reg == LAST_BLINK) begin
         blink_cnt_reg   <= '0;
         blink_phase_reg <= ~blink_phase_reg;
      end else begin
         blink_cnt_reg   <= blink_cnt_reg + 1'b1;
      end
   end

   assign dark = blank_mask[digit_reg] | (blink_phase_reg & edit_sel[digit_reg]);
`else
   assign dark = blank_mask[digit_reg];
`endif

   always_ff @(posedge clk) begin
      if (rst || dark) begin
         an  <= '1;
         seg <= 7'h7F;
         dp  <= 1'b1;
      end else begin
         an  <= ~(NUM_DIGITS'(1) << digit_reg);
         seg <= decode(cur_nibble);
         dp  <= ~dp_mask[digit_reg];
      end
   end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Randomized bench for seven_seg_scan: a cycle-count based model predicts an/seg/dp each cycle.
// Build with SEVEN_SEG_BLINK_EN defined to exercise the blink path.
module tb_seven_seg_scan;

   localparam int ND = 4;
   localparam int RD = 4;
   localparam int BD = 8;
`ifdef SEVEN_SEG_BLINK_EN
   localparam bit BLINK_EN = 1'b1;
`else
   localparam bit BLINK_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [15:0]   digits_in;
   logic          load;
   logic [3:0]    blank_mask;
   logic [3:0]    dp_mask;
   logic [3:0]    edit_sel;
   logic [6:0]    seg;
   logic          dp;
   logic [3:0]    an;

   seven_seg_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
      .clk        (clk),
      .rst        (rst),
      .digits_in  (digits_in),
      .load       (load),
      .blank_mask (blank_mask),
      .dp_mask    (dp_mask),
`ifdef SEVEN_SEG_BLINK_EN
      .edit_sel   (edit_sel),
`endif
      .seg        (seg),
      .dp         (dp),
      .an         (an)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
      n_vec++;
      if (act !== req) begin
         n_miss++;
         $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
      end
   endtask

   // Segment table for values 0..15, active-low {g..a}.
   logic [6:0] seg_tab [16];
   initial begin
      seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
      seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
      seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
      seg_tab[9] = 7'b0010000;
      for (int i = 10; i < 16; i++) seg_tab[i] = 7'b0111111;
   end

   // Model: n = clock edges since reset release; active digit is (n/RD)%ND.
   logic [15:0] m_shadow = '0;
   int          m_n = 0;
   int          m_d;
   logic        m_dark;
   logic        valid = 1'b0;
   logic [3:0]  exp_an;
   logic [6:0]  exp_seg;
   logic        exp_dp;

   always @(posedge clk) begin
      if (rst) begin
         exp_an   = 4'hF;
         exp_seg  = 7'h7F;
         exp_dp   = 1'b1;
         m_shadow = '0;
         m_n      = 0;
      end else begin
         m_d    = (m_n / RD) % ND;
         m_dark = blank_mask[m_d];
         if (BLINK_EN && ((m_n / BD) % 2 == 1) && edit_sel[m_d]) m_dark = 1'b1;
         if (m_dark) begin
            exp_an  = 4'hF;
            exp_seg = 7'h7F;
            exp_dp  = 1'b1;
         end else begin
            exp_an  = 4'hF ^ (4'(1) << m_d);
            exp_seg = seg_tab[(m_shadow >> (4 * m_d)) & 16'hF];
            exp_dp  = ~dp_mask[m_d];
         end
         if (load) m_shadow = digits_in;
         m_n++;
      end
      valid = 1'b1;
   end

   always @(negedge clk) begin
      if (valid) begin
         check("an",  {12'h0, an},  {12'h0, exp_an});
         check("seg", {9'h0, seg},  {9'h0, exp_seg});
         check("dp",  {15'h0, dp},  {15'h0, exp_dp});
      end
   end

   initial begin
      rst = 1'b1; load = 1'b0; digits_in = '0;
      blank_mask = '0; dp_mask = '0; edit_sel = '0;
      repeat (3) @(negedge clk);
      check("reset_an", {12'h0, an}, 16'h000F);
      check("reset_seg", {9'h0, seg}, 16'h007F);

      rst = 1'b0; load = 1'b1; digits_in = 16'h1234;
      @(negedge clk);                       // edge 1: digit 0 lit, old shadow 0
      check("first_an", {12'h0, an}, 16'h000E);
      check("first_seg", {9'h0, seg}, {9'h0, 7'b1000000});
      load = 1'b0; digits_in = 16'hFFFF;
      @(negedge clk);                       // edge 2: digit 0 shows 4
      check("d0_seg", {9'h0, seg}, {9'h0, 7'b0011001});
      repeat (3) @(negedge clk);            // edge 5: digit 1 shows 3
      check("d1_an", {12'h0, an}, 16'h000D);
      check("d1_seg", {9'h0, seg}, {9'h0, 7'b0110000});
      repeat (8) @(negedge clk);            // edge 13: digit 3 shows 1
      check("d3_an", {12'h0, an}, 16'h0007);
      check("d3_seg", {9'h0, seg}, {9'h0, 7'b1111001});
      repeat (5) @(negedge clk);            // edge 18: digit 0 again
      load = 1'b1; digits_in = 16'hA900;
      @(negedge clk);                       // edge 19 captures A900
      load = 1'b0;
      @(negedge clk);                       // edge 20: digit 0 shows 0
      check("load_lat_seg", {9'h0, seg}, {9'h0, 7'b1000000});
      repeat (8) @(negedge clk);            // edge 28: digit 2 shows 9
      check("d2_nine", {9'h0, seg}, {9'h0, 7'b0010000});
      repeat (4) @(negedge clk);            // edge 32: digit 3 shows dash
      check("d3_dash", {9'h0, seg}, {9'h0, 7'b0111111});

      blank_mask = 4'b1000; dp_mask = 4'b0010; edit_sel = 4'b0001;
      repeat (24) @(negedge clk);

      rst = 1'b1;
      @(negedge clk);
      check("midrst_an", {12'h0, an}, 16'h000F);
      check("midrst_dp", {15'h0, dp}, 16'h0001);
      rst = 1'b0; blank_mask = '0; dp_mask = '0;
      @(negedge clk);
      check("postrst_seg", {9'h0, seg}, {9'h0, 7'b1000000});

      for (int i = 0; i < 600; i++) begin
         digits_in = 16'($urandom);
         load      = ($urandom_range(0, 3) == 0);
         rst       = ($urandom_range(0, 79) == 0);
         if ($urandom_range(0, 15) == 0) blank_mask = 4'($urandom) & 4'($urandom);
         if ($urandom_range(0, 15) == 0) dp_mask    = 4'($urandom);
         if ($urandom_range(0, 31) == 0) edit_sel   = 4'($urandom);
         @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
Display-side reader for the stopwatch's set/count value. It latches a packed BCD word on a load strobe and time-multiplexes it onto a common-anode multi-digit seven-segment display. It provides per-digit blanking and decimal points. It sits between the stopwatch/number-setting logic and the board's seg/an/dp pins.

Parameters:
NUM_DIGITS, 4, number of display digits scanned
REFRESH_DIV, 100000, clk cycles each digit stays active (>=2)
BLINK_DIV, 25000000, clk cycles per blink half-period (used only with SEVEN_SEG_BLINK_EN)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
digits_in  input  4*NUM_DIGITS  packed BCD value; [3:0] = digit 0 (rightmost, an[0])
load  input  1  1-cycle strobe; capture digits_in into shadow register
blank_mask  input  NUM_DIGITS  bit i = 1 keeps digit i dark
dp_mask  input  NUM_DIGITS  bit i = 1 lights decimal point of digit i
seg  output  7  segments {g,f,e,d,c,b,a}, active-low
dp  output  1  decimal point, active-low
an  output  NUM_DIGITS  digit anodes, active-low, one-hot-low when active

Behaviour:
- rst is synchronous, active-high, and dominates all other inputs. At reset: shadow=0, tick_cnt=0, digit_idx=0, an=all 1, seg=7'h7F, dp=1.
- Shadow register: on a clk edge with load=1 and rst=0, shadow <= digits_in. Otherwise it holds. digits_in is ignored when load=0.
- Prescaler: tick_cnt counts 0..REFRESH_DIV-1 and wraps to 0. On the wrap edge, digit_idx <= (digit_idx+1) mod NUM_DIGITS.
- digit_idx wraps from NUM_DIGITS-1 to 0. No skipped or repeated digits.
- Outputs are registered every cycle from the current digit_idx and shadow:
  - an = ~(1<<digit_idx), unless blank_mask[digit_idx]=1, in which case an = all 1.
  - seg = decode(shadow nibble[digit_idx]), or 7'h7F if blanked.
  - dp = ~dp_mask[digit_idx], or 1 if blanked.
- Latency: load at edge N makes the new value visible on seg at edge N+1, for whichever digit is active. Mask changes appear on the next edge.
- Decode, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10..15 = 0111111 (dash, g only)
- Simultaneous load and digit advance on the same edge: both take effect, with no priority between them.
- Reset mid-scan returns to digit 0 and the all-dark state on the next edge. The first lit digit after reset release is digit 0, one cycle after release.
- First digit after reset is held REFRESH_DIV cycles, as are all later digits.

Optional Feature:
SEVEN_SEG_BLINK_EN:
- Defined:
  - Adds input edit_sel [NUM_DIGITS-1:0] and a blink counter 0..BLINK_DIV-1.
  - A blink_phase flop toggles on each counter wrap. Reset gives counter=0, phase=0 (lit).
  - While blink_phase=1, digits with edit_sel[i]=1 are treated as blanked (an bit high, seg 7'h7F, dp 1). This marks the digit being edited.
- Undefined: no port, no counter, no blink_phase. Behaviour is exactly as above.

Test Plan (sim with REFRESH_DIV=4, NUM_DIGITS=4, BLINK_DIV=8):
1. Reset: hold rst 3 cycles -> an=4'b1111, seg=7'h7F, dp=1 throughout. One cycle after release, an=4'b1110.
2. Scan order: load 16'h1234, then run 16 cycles.
   - an goes 1110,1101,1011,0111, each held 4 cycles, then wraps to 1110.
   - seg for an=1110 is 0011001 (4); for an=0111 it is 1111001 (1).
3. Decode and load latency:
   - load 16'hA900 mid-digit-0 -> seg=1000000 (0) on the next edge.
   - When the scan reaches digit 3 -> seg=0111111 (dash); digit 2 -> seg=0010000 (9).
4. Masks and collisions:
   - blank_mask=4'b1000, dp_mask=4'b0010 -> an[3] never low, and seg=7'h7F in that slot. dp=0 only while an=1101.
   - Assert load on a digit-advance edge -> new index and new value both appear on the next edge.
5. Reset mid-scan at digit 2 with shadow=16'h5678 -> outputs go dark next edge and shadow=0. After release, seg=1000000 on digit 0.
6. Blink (macro defined): edit_sel=4'b0001 -> digit 0 alternates lit and dark every 8 cycles, other digits unaffected. With the macro undefined, digit 0 is never dark.
